uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter CLK_FREQ SHALL default to 50000000, meaning the clk frequency in Hz.
REQ-003 Parameter BAUD SHALL default to 115200, meaning the serial bit rate in bit/s.
REQ-004 Derived constant BIT_DIV SHALL equal CLK_FREQ/BAUD (integer truncation, 434 at defaults); HALF_DIV SHALL equal BIT_DIV/2 (217).
REQ-005 Port: clk  input  1  system clock, all logic on rising edge.
REQ-006 Port: reset  input  1  synchronous active-high reset.
REQ-007 Port: uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 Port: data_out  output  8  last correctly framed byte; feeds the downstream character checker's data_in.
REQ-009 Port: data_out_valid  output  1  one-cycle pulse qualifying data_out; feeds the checker's data_in_valid.
REQ-010 Port: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer plus one history flop before use; all three flops reset to 1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, with a bit-period counter (>= 9 bits) and a 3-bit bit index.
REQ-014 IDLE: on synchronized falling edge (history=1, current=0) -> START, counter cleared; otherwise stay.
REQ-015 START: the FSM SHALL count to HALF_DIV-1, then sample; sample 0 -> DATA (counter, bit index cleared), sample 1 -> IDLE with no output (glitch reject).
REQ-016 DATA: the FSM SHALL count to BIT_DIV-1, then shift the sample into bit position [bit index] (LSB first), clear the counter, and increment the bit index; after the 8th sample -> STOP.
REQ-017 STOP: the FSM SHALL count to BIT_DIV-1, then sample; sample 1 -> load data_out, pulse data_out_valid, go to IDLE.
REQ-018 STOP with sample 0: the block SHALL pulse frame_err, leave data_out unchanged, assert no data_out_valid, and go to IDLE.
REQ-019 data_out_valid and frame_err SHALL be registered, high for exactly one clk cycle, and never high together.
REQ-020 data_out SHALL hold its value between valid pulses.
REQ-021 Latency: data_out_valid SHALL rise exactly one cycle after the stop-bit sample edge, i.e. HALF_DIV + 9*BIT_DIV + 1 cycles after START entry.
REQ-022 Back-to-back frames (stop bit followed immediately by the next start bit) SHALL be received without loss, since STOP exits at mid-stop-bit.
REQ-023 A line held low after a frame error (break) SHALL NOT retrigger reception until a falling edge follows a return to high.
REQ-024 The block SHALL ignore uart_rx activity while in START, DATA or STOP beyond the scheduled samples.

Reset
REQ-025 While reset=1 at a clk edge, the block SHALL set state to IDLE, counters and the shift register to 0, data_out=8'h00, data_out_valid=0, frame_err=0, busy=0, and synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse; the next complete frame after reset deasserts SHALL be received correctly.

Verification
REQ-027 Send 0x68 ('h') at 115200 baud -> data_out=8'h68, data_out_valid high for one cycle at the REQ-021 latency, frame_err=0.
REQ-028 Send "hello" (0x68 65 6C 6C 6F) back-to-back with one stop bit each -> five valid pulses carrying exactly those bytes in order.
REQ-029 Drive a low glitch of 100 clk cycles on an idle line -> no data_out_valid, no frame_err; busy high less than 220 cycles.
REQ-030 Send 0x41 with stop bit forced to 0 -> one frame_err pulse, no valid pulse, data_out keeps its previous value.
REQ-031 Assert reset for 1 cycle during bit 4 of 0x55, then send 0x49 -> only one valid pulse, data_out=8'h49.
REQ-032 Hold uart_rx low for 20 bit periods, then release high and send 0x6F -> exactly one frame_err, then one valid pulse with 8'h6F.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit at its
// midpoint and reports a framed byte or a stop-bit error as one-cycle pulses.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT_DIV  = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BIT_DIV / 2;
    localparam int CNT_W    = ($clog2(BIT_DIV) > 9) ? $clog2(BIT_DIV) : 9;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_hist;
    logic             stop_ok;
    logic             stop_bad;

    assign busy = (state != IDLE);

    // The stop-bit verdict is staged through stop_ok/stop_bad so the output
    // pulses appear one cycle after the sample edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_err      <= 1'b0;
            stop_ok        <= 1'b0;
            stop_bad       <= 1'b0;
            rx_s1          <= 1'b1;
            rx_s2          <= 1'b1;
            rx_hist        <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_hist <= rx_s2;

            data_out_valid <= stop_ok;
            frame_err      <= stop_bad;
            if (stop_ok) begin
                data_out <= shift;
            end
            stop_ok  <= 1'b0;
            stop_bad <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_hist && !rx_s2) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        shift[bit_idx] <= rx_s2;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        stop_ok  <= rx_s2;
                        stop_bad <= !rx_s2;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at a reduced bit period (16 clocks per bit)
// so every scenario fits in a short run.
module tb_uart_byte_rx;

    localparam int BIT  = 16;   // 50 MHz / 3 Mbaud, truncated
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_err;
    logic       busy;

    uart_byte_rx #(
        .CLK_FREQ(50_000_000),
        .BAUD    (3_000_000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int         cyc        = 0;
    int         n_valid    = 0;
    int         n_ferr     = 0;
    int         overlap    = 0;
    int         long_pulse = 0;
    int         busy_rise  = 0;
    int         valid_rise = 0;
    int         busy_run   = 0;
    int         last_busy_len = 0;
    logic       valid_d = 1'b0;
    logic       ferr_d  = 1'b0;
    logic       busy_d  = 1'b0;
    logic [7:0] got[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (data_out_valid) begin
            n_valid = n_valid + 1;
            got.push_back(data_out);
            if (valid_d) long_pulse = long_pulse + 1;
        end
        if (frame_err) begin
            n_ferr = n_ferr + 1;
            if (ferr_d) long_pulse = long_pulse + 1;
        end
        if (data_out_valid && frame_err) overlap = overlap + 1;
        if (busy && !busy_d) busy_rise = cyc;
        if (data_out_valid && !valid_d) valid_rise = cyc;
        if (busy) busy_run = busy_run + 1;
        else begin
            if (busy_d) last_busy_len = busy_run;
            busy_run = 0;
        end
        valid_d = data_out_valid;
        ferr_d  = frame_err;
        busy_d  = busy;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt = total_cnt + 1;
        if (act == exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_out;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] hello[5];
    int         v0;
    int         f0;
    int         q0;

    initial begin
        vecs[0] = '{8'h68, 1'b1, 1, 0, 8'h68};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[4] = '{8'h41, 1'b0, 0, 1, 8'hA5};
        vecs[5] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        hello[0] = 8'h68; hello[1] = 8'h65; hello[2] = 8'h6C;
        hello[3] = 8'h6C; hello[4] = 8'h6F;

        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        idle_bits(2);

        // Single 'h' frame with latency measured from busy rise to valid rise
        send_frame(8'h68, 1'b1);
        idle_bits(2);
        check("h_valid_count", n_valid, 1);
        check("h_frame_err", n_ferr, 0);
        check("h_data", int'(data_out), 8'h68);
        check("h_latency", valid_rise - busy_rise, HALF + 9 * BIT + 1);

        for (int i = 0; i < 6; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop);
            idle_bits(2);
            check($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_data", i), int'(data_out), int'(vecs[i].exp_out));
        end

        v0 = n_valid;
        q0 = got.size();
        for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1);
        idle_bits(2);
        check("hello_count", n_valid - v0, 5);
        for (int i = 0; i < 5; i++) begin
            if (got.size() > q0 + i)
                check($sformatf("hello_byte%0d", i), int'(got[q0 + i]), int'(hello[i]));
            else
                check($sformatf("hello_byte%0d_missing", i), 1, 0);
        end

        v0 = n_valid;
        f0 = n_ferr;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        idle_bits(3);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_busy_len", last_busy_len, HALF);

        // Reset one cycle in the middle of data bit 4 of 0x55
        v0 = n_valid;
        f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i % 2 == 0);
        uart_rx = 1'b1;
        repeat (HALF) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_data_out", int'(data_out), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (BIT - HALF - 1) @(negedge clk);
        for (int i = 5; i < 8; i++) send_bit(i % 2 == 0);
        send_bit(1'b1);
        check("midrst_no_valid", n_valid - v0, 0);
        check("midrst_no_ferr", n_ferr - f0, 0);
        idle_bits(12);
        v0 = n_valid;
        send_frame(8'h49, 1'b1);
        idle_bits(2);
        check("after_rst_valid", n_valid - v0, 1);
        check("after_rst_data", int'(data_out), 8'h49);

        v0 = n_valid;
        f0 = n_ferr;
        uart_rx = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        check("break_ferr", n_ferr - f0, 1);
        check("break_valid", n_valid - v0, 0);
        check("break_busy", int'(busy), 0);
        check("break_data_kept", int'(data_out), 8'h49);
        idle_bits(2);
        send_frame(8'h6F, 1'b1);
        idle_bits(2);
        check("post_break_valid", n_valid - v0, 1);
        check("post_break_ferr", n_ferr - f0, 1);
        check("post_break_data", int'(data_out), 8'h6F);

        check("valid_ferr_overlap", overlap, 0);
        check("pulse_width", long_pulse, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
